mc_ctrl_unit: RTL and testbench
===============================

Name: mc_ctrl_unit

Overview:
Multi-cycle MIPS-subset control FSM that drives the 3-bit ALU control code and all datapath strobes for the 32-bit ALU and its surrounding datapath. It consumes the ALU's zero flag and sits between the instruction register and the datapath. One instruction spans 3–5 states. Memory states stall on a ready handshake.

Parameters:
ST_W, 4, state register width; also the width of the state_dbg port.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  6  IR[31:26] opcode
funct  in  6  IR[5:0] R-type function field
zero  in  1  ALU zero flag
mem_rdy  in  1  memory completes the current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load qualified by zero (beq)
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
reg_dst  out  1  write register: 0=rt, 1=rd
mem_to_reg  out  1  write-back data: 0=ALUOut, 1=MDR
reg_write  out  1  register-file write enable
alu_src_a  out  1  ALU A input: 0=PC, 1=rs
alu_src_b  out  2  ALU B input: 00=rt, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2
alu_ctr  out  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
pc_source  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
halt  out  1  trap state indicator (sticky)
state_dbg  out  ST_W  current state, for debug

Behaviour:
- Reset: rst_n low → state=IDLE asynchronously. All outputs are 0 in IDLE, including alu_ctr=000 and state_dbg=0.
- IDLE → FETCH unconditionally on the next clock.
- Decoding: outputs are decoded from the registered state. pc_write and ir_write in FETCH are additionally ANDed with mem_rdy. No other output depends on inputs.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctr=010, pc_source=00.
  - Stays in FETCH while mem_rdy=0.
  - When mem_rdy=1: ir_write=1, pc_write=1, next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctr=010 (branch target precompute). Next state by op:
  - 0x00 → R_EXE
  - 0x23, 0x2B → MEM_ADR
  - 0x04 → BEQ_EXE
  - 0x02 → J_EXE
  - 0x08, 0x0C, 0x0D, 0x0A → I_EXE
  - any other op → TRAP
- R_EXE: alu_src_a=1, alu_src_b=00. alu_ctr from funct: 0x20→010, 0x22→110, 0x24→000, 0x25→001, 0x2A→111; any other funct → TRAP next. Otherwise next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- MEM_ADR: alu_src_a=1, alu_src_b=10, alu_ctr=010. Next: lw → MEM_RD, sw → MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Held until mem_rdy=1, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Held until mem_rdy=1, then FETCH. mem_write stays high throughout the stall.
- BEQ_EXE: alu_src_a=1, alu_src_b=00, alu_ctr=110, pc_write_cond=1, pc_source=01 → FETCH. The datapath loads PC iff zero=1.
- J_EXE: pc_write=1, pc_source=10 → FETCH.
- I_EXE: alu_src_a=1, alu_src_b=10. alu_ctr by op: addi 010, andi 000, ori 001, slti 111 → I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- TRAP: halt=1, all other outputs 0. Exited only by reset.
- Encoding: state IDLE=0, FETCH=1, DECODE=2, MEM_ADR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXE=7, R_WB=8, BEQ_EXE=9, J_EXE=10, I_EXE=11, I_WB=12, TRAP=15. Unused encodings (13, 14) → TRAP.
- Reset mid-instruction (including during a mem_rdy stall): immediate return to IDLE, all strobes drop in the same delta; no partial write-back.
- op/funct are sampled only in DECODE/R_EXE/I_EXE/MEM_ADR. The IR must hold them stable from FETCH exit until the next FETCH.
- CPI: R/I-type 4, lw 5, sw 4, beq 3, j 3, each plus memory stall cycles.

Decomposition:
- Package mc_ctrl_pkg:
  - state enum/localparams
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI)
  - funct constants
  - ALU code constants (ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111)
- Sub-module alu_ctr_dec: combinational. Inputs op, funct, state-class. Outputs alu_ctr[2:0] and an illegal flag. Instantiated once.

Test Plan:
- Reset release, mem_rdy=1, op=0x00, funct=0x20 → states 0,1,2,7,8,1. alu_ctr: 010 in FETCH, 010 in DECODE, 010 in R_EXE. reg_write=1, reg_dst=1 in R_WB.
- lw (op=0x23), mem_rdy low for 3 cycles in MEM_RD → mem_read and i_or_d held 3 extra cycles. MEM_WB has mem_to_reg=1, reg_write=1 exactly one cycle. Total 8 cycles FETCH→FETCH.
- beq (op=0x04) with zero=1 and zero=0 → BEQ_EXE has alu_ctr=110, pc_write_cond=1, pc_source=01, and pc_write=0 in both cases.
- R-type funct=0x2A → alu_ctr=111. funct=0x3F → TRAP, halt=1, stays there for 20 cycles until rst_n pulse → IDLE, halt=0.
- sw (op=0x2B) with rst_n asserted during a MEM_WR stall → mem_write falls asynchronously, state_dbg=0, then FETCH one cycle after rst_n rises.
- ori (op=0x0D) → I_EXE has alu_src_b=10, alu_ctr=001. I_WB has reg_dst=0. Illegal op=0x3F in DECODE → TRAP.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control unit.
// Contents: state encoding, ALU-code class selector, opcode/funct constants and ALU codes.
package mc_ctrl_pkg;

  // Encodings are fixed; state_dbg exposes them directly.
  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAdr  = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StRExe    = 4'd7,
    StRWb     = 4'd8,
    StBeqExe  = 4'd9,
    StJExe    = 4'd10,
    StIExe    = 4'd11,
    StIWb     = 4'd12,
    StTrap    = 4'd15
  } state_e;

  // Selects how the ALU code is derived in the current state.
  typedef enum logic [2:0] {
    AluClsNone  = 3'd0,  // ALU idle, code 000
    AluClsAdd   = 3'd1,  // fixed ADD (PC+4, branch target, address)
    AluClsSub   = 3'd2,  // fixed SUB (beq compare)
    AluClsFunct = 3'd3,  // R-type: from funct
    AluClsOp    = 3'd4   // I-type: from opcode
  } alu_cls_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_ctrl_unit_alu_dec.sv
// alu_ctr_dec: combinational ALU control-code decoder.
// Ports: i_op/i_funct (instruction fields), i_cls (derivation class from the FSM),
//        o_alu_ctr (3-bit ALU code), o_illegal (field not decodable for this class).
module alu_ctr_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  alu_cls_e   i_cls,
  output logic [2:0] o_alu_ctr,
  output logic       o_illegal
);

  always_comb begin
    o_alu_ctr = ALU_AND;
    o_illegal = 1'b0;
    case (i_cls)
      AluClsAdd: o_alu_ctr = ALU_ADD;
      AluClsSub: o_alu_ctr = ALU_SUB;
      AluClsFunct: begin
        case (i_funct)
          FN_ADD:  o_alu_ctr = ALU_ADD;
          FN_SUB:  o_alu_ctr = ALU_SUB;
          FN_AND:  o_alu_ctr = ALU_AND;
          FN_OR:   o_alu_ctr = ALU_OR;
          FN_SLT:  o_alu_ctr = ALU_SLT;
          default: o_illegal = 1'b1;
        endcase
      end
      AluClsOp: begin
        case (i_op)
          OP_ADDI: o_alu_ctr = ALU_ADD;
          OP_ANDI: o_alu_ctr = ALU_AND;
          OP_ORI:  o_alu_ctr = ALU_OR;
          OP_SLTI: o_alu_ctr = ALU_SLT;
          default: o_illegal = 1'b1;
        endcase
      end
      default: o_alu_ctr = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multi-cycle MIPS-subset control FSM.
// Inputs:  clk, rst_n (async active-low), op/funct (from IR), zero (ALU flag),
//          mem_rdy (memory access completes this cycle).
// Outputs: datapath strobes (PC, memory, IR, register file, ALU muxes), alu_ctr,
//          pc_source, halt (trap indicator) and state_dbg (current state code).
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ST_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [5:0]      op,
  input  logic [5:0]      funct,
  input  logic            zero,
  input  logic            mem_rdy,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            i_or_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [2:0]      alu_ctr,
  output logic [1:0]      pc_source,
  output logic            halt,
  output logic [ST_W-1:0] state_dbg
);

  state_e   r_state;
  state_e   w_state_nxt;
  alu_cls_e w_alu_cls;
  logic     w_alu_illegal;

  // zero is consumed by the datapath through pc_write_cond; the FSM never branches on it.
  logic w_zero_unused;
  assign w_zero_unused = zero;

  alu_ctr_dec u_alu_ctr_dec (
    .i_op      (op),
    .i_funct   (funct),
    .i_cls     (w_alu_cls),
    .o_alu_ctr (alu_ctr),
    .o_illegal (w_alu_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  assign state_dbg = ST_W'(r_state);

  always_comb begin
    w_state_nxt   = r_state;
    w_alu_cls     = AluClsNone;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    halt          = 1'b0;
    case (r_state)
      StIdle: w_state_nxt = StFetch;
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        w_alu_cls = AluClsAdd;
        // PC+4 and IR capture only commit on the cycle the fetch completes.
        pc_write  = mem_rdy;
        ir_write  = mem_rdy;
        if (mem_rdy) w_state_nxt = StDecode;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        w_alu_cls = AluClsAdd;
        case (op)
          OP_RTYPE:                         w_state_nxt = StRExe;
          OP_LW, OP_SW:                     w_state_nxt = StMemAdr;
          OP_BEQ:                           w_state_nxt = StBeqExe;
          OP_J:                             w_state_nxt = StJExe;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_state_nxt = StIExe;
          default:                          w_state_nxt = StTrap;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_alu_cls = AluClsAdd;
        // op can only change here if the IR was disturbed; treat that as illegal.
        if (op == OP_LW)      w_state_nxt = StMemRd;
        else if (op == OP_SW) w_state_nxt = StMemWr;
        else                  w_state_nxt = StTrap;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_rdy) w_state_nxt = StMemWb;
      end
      StMemWb: begin
        reg_write   = 1'b1;
        mem_to_reg  = 1'b1;
        w_state_nxt = StFetch;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_rdy) w_state_nxt = StFetch;
      end
      StRExe: begin
        alu_src_a   = 1'b1;
        w_alu_cls   = AluClsFunct;
        w_state_nxt = w_alu_illegal ? StTrap : StRWb;
      end
      StRWb: begin
        reg_write   = 1'b1;
        reg_dst     = 1'b1;
        w_state_nxt = StFetch;
      end
      StBeqExe: begin
        alu_src_a     = 1'b1;
        w_alu_cls     = AluClsSub;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        w_state_nxt   = StFetch;
      end
      StJExe: begin
        pc_write    = 1'b1;
        pc_source   = 2'b10;
        w_state_nxt = StFetch;
      end
      StIExe: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        w_alu_cls   = AluClsOp;
        w_state_nxt = w_alu_illegal ? StTrap : StIWb;
      end
      StIWb: begin
        reg_write   = 1'b1;
        w_state_nxt = StFetch;
      end
      StTrap: begin
        halt        = 1'b1;
        w_state_nxt = StTrap;
      end
      default: w_state_nxt = StTrap;  // unused encodings
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Self-checking bench for mc_ctrl_unit: a driver steps directed instruction sequences and
// queues the hand-derived expected output word per cycle; a monitor compares on negedge.
module tb_mc_ctrl_unit;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DEC = 4'd2, S_MADR = 4'd3,
                         S_MRD = 4'd4, S_MWB = 4'd5, S_MWR = 4'd6, S_REXE = 4'd7,
                         S_RWB = 4'd8, S_BEQ = 4'd9, S_J = 4'd10, S_IEXE = 4'd11,
                         S_IWB = 4'd12, S_TRAP = 4'd15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'h00, funct = 6'h00;
  logic       zero = 1'b0, mem_rdy = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, halt;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_ctr;
  logic [3:0] state_dbg;

  mc_ctrl_unit #(.ST_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .funct         (funct),
    .zero          (zero),
    .mem_rdy       (mem_rdy),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_ctr       (alu_ctr),
    .pc_source     (pc_source),
    .halt          (halt),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [21:0] exp;
  } pkt_t;

  pkt_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Expected output word for a state, built from the per-state strobe table.
  function automatic logic [21:0] ev(input logic [3:0] st, input logic rdy,
                                     input logic [2:0] alu);
    logic pw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa, h;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa, h} = '0;
    sb = 2'b00; ps = 2'b00; ac = 3'b000;
    case (st)
      S_FETCH: begin mr = 1; sb = 2'b01; ac = 3'b010; pw = rdy; irw = rdy; end
      S_DEC:   begin sb = 2'b11; ac = 3'b010; end
      S_MADR:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
      S_MRD:   begin mr = 1; iod = 1; end
      S_MWB:   begin rw = 1; m2r = 1; end
      S_MWR:   begin mw = 1; iod = 1; end
      S_REXE:  begin sa = 1; ac = alu; end
      S_RWB:   begin rw = 1; rd = 1; end
      S_BEQ:   begin sa = 1; ac = 3'b110; pwc = 1; ps = 2'b01; end
      S_J:     begin pw = 1; ps = 2'b10; end
      S_IEXE:  begin sa = 1; sb = 2'b10; ac = alu; end
      S_IWB:   begin rw = 1; end
      S_TRAP:  begin h = 1; end
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa, sb, ac, ps, h, st};
  endfunction

  function automatic logic [21:0] actual();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
            mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctr, pc_source, halt, state_dbg};
  endfunction

  // Monitor: every cycle that has a queued expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      pkt_t p;
      logic [21:0] act;
      p = sb_q.pop_front();
      act = actual();
      n_vec++;
      if (act !== p.exp) begin
        n_err++;
        $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                 p.tag, act, act[3:0], p.exp, p.exp[3:0]);
      end
    end
  end

  // Apply mem_rdy for this cycle, queue its expectation, advance past the next edge.
  task automatic cyc(input string tag, input logic rdy, input logic [21:0] e);
    mem_rdy = rdy;
    sb_q.push_back('{tag, e});
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [5:0] o, input logic [5:0] f, input string nm);
    op = o;
    funct = f;
    cyc({nm, " fetch"}, 1'b1, ev(S_FETCH, 1'b1, 3'b000));
    cyc({nm, " decode"}, 1'b1, ev(S_DEC, 1'b0, 3'b000));
  endtask

  initial begin
    @(posedge clk);
    #1;
    cyc("reset held", 1'b1, ev(S_IDLE, 1'b0, 3'b000));
    rst_n = 1'b1;
    cyc("idle after release", 1'b1, ev(S_IDLE, 1'b0, 3'b000));

    // add: 0,1,2,7,8,1 with a one-cycle fetch stall first
    op = 6'h00; funct = 6'h20;
    cyc("fetch stall", 1'b0, ev(S_FETCH, 1'b0, 3'b000));
    fetch_decode(6'h00, 6'h20, "add");
    cyc("add r_exe", 1'b1, ev(S_REXE, 1'b0, 3'b010));
    cyc("add r_wb", 1'b1, ev(S_RWB, 1'b0, 3'b000));

    // lw with 3 stall cycles in MEM_RD: 8 cycles FETCH to FETCH
    fetch_decode(6'h23, 6'h00, "lw");
    cyc("lw mem_adr", 1'b0, ev(S_MADR, 1'b0, 3'b000));
    for (int i = 0; i < 3; i++) cyc("lw mem_rd stall", 1'b0, ev(S_MRD, 1'b0, 3'b000));
    cyc("lw mem_rd done", 1'b1, ev(S_MRD, 1'b0, 3'b000));
    cyc("lw mem_wb", 1'b0, ev(S_MWB, 1'b0, 3'b000));

    // beq with zero=1 then zero=0: outputs identical, no unconditional pc_write
    zero = 1'b1;
    fetch_decode(6'h04, 6'h00, "beq z1");
    cyc("beq z1 exe", 1'b1, ev(S_BEQ, 1'b0, 3'b000));
    zero = 1'b0;
    fetch_decode(6'h04, 6'h00, "beq z0");
    cyc("beq z0 exe", 1'b1, ev(S_BEQ, 1'b0, 3'b000));

    // j
    fetch_decode(6'h02, 6'h00, "j");
    cyc("j exe", 1'b1, ev(S_J, 1'b0, 3'b000));

    // ori, then andi
    fetch_decode(6'h0D, 6'h00, "ori");
    cyc("ori i_exe", 1'b1, ev(S_IEXE, 1'b0, 3'b001));
    cyc("ori i_wb", 1'b1, ev(S_IWB, 1'b0, 3'b000));
    fetch_decode(6'h0C, 6'h00, "andi");
    cyc("andi i_exe", 1'b1, ev(S_IEXE, 1'b0, 3'b000));
    cyc("andi i_wb", 1'b1, ev(S_IWB, 1'b0, 3'b000));

    // sub, slt
    fetch_decode(6'h00, 6'h22, "sub");
    cyc("sub r_exe", 1'b1, ev(S_REXE, 1'b0, 3'b110));
    cyc("sub r_wb", 1'b1, ev(S_RWB, 1'b0, 3'b000));
    fetch_decode(6'h00, 6'h2A, "slt");
    cyc("slt r_exe", 1'b1, ev(S_REXE, 1'b0, 3'b111));
    cyc("slt r_wb", 1'b1, ev(S_RWB, 1'b0, 3'b000));

    // illegal funct: R_EXE alu code unspecified, so that cycle is not queued
    fetch_decode(6'h00, 6'h3F, "bad funct");
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) cyc("trap sticky", 1'b1, ev(S_TRAP, 1'b0, 3'b000));
    rst_n = 1'b0;
    cyc("trap reset", 1'b1, ev(S_IDLE, 1'b0, 3'b000));
    rst_n = 1'b1;
    cyc("idle after trap", 1'b1, ev(S_IDLE, 1'b0, 3'b000));

    // sw, reset asserted between edges during a MEM_WR stall
    fetch_decode(6'h2B, 6'h00, "sw");
    cyc("sw mem_adr", 1'b0, ev(S_MADR, 1'b0, 3'b000));
    cyc("sw mem_wr stall", 1'b0, ev(S_MWR, 1'b0, 3'b000));
    #1;
    rst_n = 1'b0;
    cyc("sw async reset", 1'b0, ev(S_IDLE, 1'b0, 3'b000));
    rst_n = 1'b1;
    cyc("idle after sw reset", 1'b1, ev(S_IDLE, 1'b0, 3'b000));

    // FETCH one cycle after release, then illegal opcode traps from DECODE
    fetch_decode(6'h3F, 6'h00, "bad op");
    cyc("bad op trap", 1'b1, ev(S_TRAP, 1'b0, 3'b000));

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of run expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
